inverse_zigzag: RTL and testbench
=================================

// Module: inverse_zigzag
// PURPOSE
//  Decoder-side counterpart of the encoder zigzag scan. Collects a serial stream of
//  4x4 residual coefficients in zigzag order from the CAVLC decoder and rebuilds the
//  raster-order 4x4 block. Hands the block to inverse quant/IDCT over a valid/ready
//  handshake. Supports early end-of-block (trailing zeros) and whole-zero blocks.
// PARAMETERS
//  DW     15  coefficient width, signed two's complement
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     synchronous reset, active-high
//  coef_valid in   1     coef_in carries the next zigzag coefficient
//  coef_in    in   DW    signed coefficient, zigzag index = internal count
//  coef_last  in   1     with coef_valid: this is the last coded coef; the rest are zero
//  coef_ready out  1     block accepts a coefficient this cycle
//  zero_blk   in   1     pulse: emit an all-zero block (uncoded block)
//  blk_valid  out  1     dout_* hold a complete block
//  blk_ready  in   1     consumer takes the block this cycle
//  blk_ncoef  out  5     coefficients accepted for the presented block, 0..16
//  dout_rc    out  DW    16 signed outputs, r=row 0..3, c=col 0..3 (dout_00..dout_33)
// BEHAVIOUR
//  - State machine: FILL (collecting) and OUT (block presented). Counter cnt is 4 bits.
//  - Reset: state=FILL, cnt=0, all 16 registers=0, blk_valid=0, blk_ncoef=0.
//    coef_ready=1 from the first cycle after reset.
//  - coef_ready = (state==FILL) && !(zero_blk && cnt==0). This is combinational.
//  - Accept occurs when coef_valid && coef_ready. The coefficient is written to the
//    raster position for zigzag index cnt, and cnt increments.
//  - Zigzag index k maps to (row,col) as follows:
//      0:00 1:01 2:10 3:20 4:11 5:02 6:03 7:12
//      8:21 9:30 10:31 11:22 12:13 13:23 14:32 15:33
//  - End of fill is an accept with cnt==15 or with coef_last=1.
//    The next cycle has state=OUT and blk_valid=1. blk_ncoef = cnt+1 at that accept.
//    Unwritten positions read as 0. coef_last on index 15 is the same as a normal 16th coef.
//  - zero_blk is sampled only in FILL with cnt==0.
//    The next cycle has state=OUT, blk_valid=1, all outputs 0, blk_ncoef=0.
//    zero_blk is ignored when cnt!=0 or in OUT.
//    zero_blk wins over a simultaneous coef_valid at cnt==0; that coef is not accepted.
//  - OUT: dout_*, blk_ncoef and blk_valid stay stable while blk_ready=0 (unlimited
//    stall). coef_ready=0 throughout OUT.
//  - Handshake in OUT is blk_valid && blk_ready. The next cycle has:
//    state=FILL, cnt=0, all registers=0, blk_valid=0, coef_ready=1.
//    There is one bubble cycle per block. No stale data carries over.
//  - Values pass through unmodified, signed. No saturation or width change.
//  - Reset mid-fill or mid-OUT discards the partial or presented block and restores
//    the reset state.
//  - Outputs are driven directly from registers. Latency from the last accepted coef
//    to blk_valid is 1 cycle.
// TESTING
//  1. Release reset -> blk_valid=0, coef_ready=1, all dout=0, blk_ncoef=0.
//  2. Stream 1..16 back-to-back -> dout_00=1, dout_01=2, dout_10=3, dout_20=4,
//     dout_11=5, dout_02=6, dout_33=16, blk_ncoef=16. blk_valid rises the cycle after the 16th coef.
//  3. Stream -5,7,9 with coef_last on 9 -> dout_00=-5, dout_01=7, dout_10=9,
//     other 13 outputs 0, blk_ncoef=3. Values -16384 and 16383 survive unchanged.
//  4. Hold blk_ready=0 for 10 cycles with coef_valid=1 -> coef_ready=0, outputs stable.
//     Then pulse blk_ready -> next cycle coef_ready=1, and a following 2-coef block shows zeros in 14 slots.
//  5. zero_blk with coef_valid at cnt=0 -> all-zero block, blk_ncoef=0, coef not taken.
//     zero_blk at cnt=5 -> ignored, fill continues.
//  6. Assert rst after 7 coefs -> cnt=0, dout all 0. A fresh 16-coef block is then correct.

Source files
------------

// File: rtl/inverse_zigzag.sv
// Inverse zigzag scan: collects 16 zigzag-ordered 4x4 coefficients and presents the
// raster-order block over a valid/ready handshake, with early end-of-block and zero blocks.
module inverse_zigzag #(
   parameter int DW = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coef_valid,
   input  logic signed [DW-1:0] coef_in,
   input  logic                 coef_last,
   output logic                 coef_ready,
   input  logic                 zero_blk,
   output logic                 blk_valid,
   input  logic                 blk_ready,
   output logic [4:0]           blk_ncoef,
   output logic signed [DW-1:0] dout_00,
   output logic signed [DW-1:0] dout_01,
   output logic signed [DW-1:0] dout_02,
   output logic signed [DW-1:0] dout_03,
   output logic signed [DW-1:0] dout_10,
   output logic signed [DW-1:0] dout_11,
   output logic signed [DW-1:0] dout_12,
   output logic signed [DW-1:0] dout_13,
   output logic signed [DW-1:0] dout_20,
   output logic signed [DW-1:0] dout_21,
   output logic signed [DW-1:0] dout_22,
   output logic signed [DW-1:0] dout_23,
   output logic signed [DW-1:0] dout_30,
   output logic signed [DW-1:0] dout_31,
   output logic signed [DW-1:0] dout_32,
   output logic signed [DW-1:0] dout_33
);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] OUT  = 1'b1;

   logic [0:0]           state;
   logic [3:0]           cnt;
   logic signed [DW-1:0] blk [16];
   logic                 accept;
   logic                 take_zero;

   // Zigzag index to raster index (row*4 + col).
   function automatic logic [3:0] raster_idx(input logic [3:0] k);
      logic [3:0] r;
      case (k)
         4'd0:    r = 4'd0;
         4'd1:    r = 4'd1;
         4'd2:    r = 4'd4;
         4'd3:    r = 4'd8;
         4'd4:    r = 4'd5;
         4'd5:    r = 4'd2;
         4'd6:    r = 4'd3;
         4'd7:    r = 4'd6;
         4'd8:    r = 4'd9;
         4'd9:    r = 4'd12;
         4'd10:   r = 4'd13;
         4'd11:   r = 4'd10;
         4'd12:   r = 4'd7;
         4'd13:   r = 4'd11;
         4'd14:   r = 4'd14;
         default: r = 4'd15;
      endcase
      return r;
   endfunction

   assign take_zero  = (state == FILL) && zero_blk && (cnt == 4'd0);
   assign coef_ready = (state == FILL) && !(zero_blk && (cnt == 4'd0));
   assign accept     = coef_valid && coef_ready;
   assign blk_valid  = (state == OUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         cnt       <= '0;
         blk_ncoef <= '0;
         for (int unsigned i = 0; i < 16; i++) blk[i] <= '0;
      end else begin
         case (state)
            FILL: begin
               // Registers are already cleared on entry to FILL, so a zero block needs no writes.
               if (take_zero) begin
                  state     <= OUT;
                  blk_ncoef <= '0;
               end else if (accept) begin
                  blk[raster_idx(cnt)] <= coef_in;
                  cnt                  <= cnt + 4'd1;
                  if (coef_last || (cnt == 4'd15)) begin
                     state     <= OUT;
                     blk_ncoef <= {1'b0, cnt} + 5'd1;
                  end
               end
            end
            default: begin
               if (blk_ready) begin
                  state     <= FILL;
                  cnt       <= '0;
                  blk_ncoef <= '0;
                  for (int unsigned i = 0; i < 16; i++) blk[i] <= '0;
               end
            end
         endcase
      end
   end

   assign dout_00 = blk[0];
   assign dout_01 = blk[1];
   assign dout_02 = blk[2];
   assign dout_03 = blk[3];
   assign dout_10 = blk[4];
   assign dout_11 = blk[5];
   assign dout_12 = blk[6];
   assign dout_13 = blk[7];
   assign dout_20 = blk[8];
   assign dout_21 = blk[9];
   assign dout_22 = blk[10];
   assign dout_23 = blk[11];
   assign dout_30 = blk[12];
   assign dout_31 = blk[13];
   assign dout_32 = blk[14];
   assign dout_33 = blk[15];

endmodule

// File: tb/tb_inverse_zigzag.sv
// Scoreboard bench for inverse_zigzag: a zigzag model built from anti-diagonal walks
// predicts each presented block; a monitor pops and compares on every handshake.
module tb_inverse_zigzag;

   localparam int DW = 15;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 coef_valid = 1'b0;
   logic signed [DW-1:0] coef_in = '0;
   logic                 coef_last = 1'b0;
   logic                 coef_ready;
   logic                 zero_blk = 1'b0;
   logic                 blk_valid;
   logic                 blk_ready = 1'b0;
   logic [4:0]           blk_ncoef;
   logic signed [DW-1:0] d [16];

   typedef struct packed {
      logic [4:0]             n;
      logic [15:0][DW-1:0]    v;
   } blk_t;

   blk_t   sb [$];
   int     checks = 0;
   int     errors = 0;
   int     popped = 0;
   int     pushed = 0;
   int     zz [16];
   int     k = 0;
   logic [15:0][DW-1:0] mdl;

   inverse_zigzag #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .coef_valid(coef_valid), .coef_in(coef_in),
      .coef_last(coef_last), .coef_ready(coef_ready), .zero_blk(zero_blk),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_ncoef(blk_ncoef),
      .dout_00(d[0]),  .dout_01(d[1]),  .dout_02(d[2]),  .dout_03(d[3]),
      .dout_10(d[4]),  .dout_11(d[5]),  .dout_12(d[6]),  .dout_13(d[7]),
      .dout_20(d[8]),  .dout_21(d[9]),  .dout_22(d[10]), .dout_23(d[11]),
      .dout_30(d[12]), .dout_31(d[13]), .dout_32(d[14]), .dout_33(d[15])
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: stability during stalls, scoreboard compare on handshake.
   logic [15:0][DW-1:0] snap;
   logic [4:0]          snap_n;
   logic                have_snap = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         have_snap = 1'b0;
      end else if (blk_valid) begin
         if (have_snap) begin
            checks++;
            for (int i = 0; i < 16; i++) begin
               if (d[i] !== snap[i] || blk_ncoef !== snap_n) begin
                  errors++;
                  $display("FAIL stall_stable[%0d]: got %0d/%0d, expected %0d/%0d",
                           i, d[i], blk_ncoef, $signed(snap[i]), snap_n);
                  break;
               end
            end
         end
         if (blk_ready) begin
            have_snap = 1'b0;
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_block: got ncoef %0d, expected no block", blk_ncoef);
            end else begin
               blk_t e;
               e = sb.pop_front();
               popped++;
               chk("blk_ncoef", int'(blk_ncoef), int'(e.n));
               checks++;
               for (int i = 0; i < 16; i++) begin
                  if (d[i] !== $signed(e.v[i])) begin
                     errors++;
                     $display("FAIL dout[r%0d c%0d]: got %0d, expected %0d",
                              i / 4, i % 4, d[i], $signed(e.v[i]));
                     break;
                  end
               end
            end
         end else begin
            for (int i = 0; i < 16; i++) snap[i] = d[i];
            snap_n    = blk_ncoef;
            have_snap = 1'b1;
         end
      end else begin
         have_snap = 1'b0;
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_blk_valid"}, int'(blk_valid), 0);
      chk({tag, "_coef_ready"}, int'(coef_ready), 1);
      chk({tag, "_blk_ncoef"}, int'(blk_ncoef), 0);
      for (int i = 0; i < 16; i++) chk({tag, "_dout"}, int'(d[i]), 0);
   endtask

   task automatic complete_block(input int n);
      blk_t e;
      e.n = 5'(n);
      e.v = mdl;
      sb.push_back(e);
      pushed++;
      k = 0;
      mdl = '0;
   endtask

   // Drive one coefficient; returns with inputs idle if it closes the block.
   task automatic send(input int val, input bit last, input bit zb);
      coef_valid = 1'b1;
      coef_in    = DW'(val);
      coef_last  = last;
      zero_blk   = zb;
      #1;
      chk("coef_ready_fill", int'(coef_ready), 1);
      @(posedge clk); #1;
      zero_blk = 1'b0;
      mdl[zz[k]] = DW'(val);
      k++;
      if (k == 16 || last) begin
         complete_block(k);
         coef_valid = 1'b0;
         coef_last  = 1'b0;
         chk("blk_valid_latency", int'(blk_valid), 1);
      end
   endtask

   task automatic send_zero(input int stray);
      zero_blk   = 1'b1;
      coef_valid = 1'b1;
      coef_in    = DW'(stray);
      #1;
      chk("coef_ready_zero_blk", int'(coef_ready), 0);
      @(posedge clk); #1;
      zero_blk   = 1'b0;
      coef_valid = 1'b0;
      complete_block(0);
      chk("blk_valid_zero_blk", int'(blk_valid), 1);
   endtask

   // Stall for the given cycles (coef_valid held high), then take the block.
   task automatic drain(input int stall);
      int bound;
      coef_valid = 1'b1;
      blk_ready  = 1'b0;
      repeat (stall) begin
         @(posedge clk); #1;
         chk("coef_ready_out", int'(coef_ready), 0);
      end
      coef_valid = 1'b0;
      blk_ready  = 1'b1;
      bound = 0;
      while (popped != pushed && bound < 50) begin
         @(posedge clk); #1;
         bound++;
      end
      blk_ready = 1'b0;
      chk("drain_timeout", int'(popped == pushed), 1);
      chk("bubble_blk_valid", int'(blk_valid), 0);
      chk("bubble_coef_ready", int'(coef_ready), 1);
   endtask

   initial begin
      // Zigzag order from anti-diagonal walks: odd diagonals go down, even go up.
      begin
         int idx = 0;
         for (int s = 0; s <= 6; s++) begin
            for (int t = 0; t <= s; t++) begin
               int r;
               r = (s % 2 == 1) ? t : s - t;
               if (r <= 3 && (s - r) <= 3) begin
                  zz[idx] = r * 4 + (s - r);
                  idx++;
               end
            end
         end
      end
      mdl = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("reset");

      for (int i = 1; i <= 16; i++) send(i, 1'b0, 1'b0);
      chk("t2_dout_00", int'(d[0]), 1);
      chk("t2_dout_20", int'(d[8]), 4);
      chk("t2_dout_33", int'(d[15]), 16);
      drain(1);

      send(-5, 1'b0, 1'b0);
      send(7, 1'b0, 1'b0);
      send(9, 1'b1, 1'b0);
      chk("t3_dout_10", int'(d[4]), 9);
      drain(0);

      send(-16384, 1'b0, 1'b0);
      send(16383, 1'b1, 1'b0);
      chk("extreme_neg", int'(d[0]), -16384);
      chk("extreme_pos", int'(d[1]), 16383);
      drain(10);
      send(3, 1'b0, 1'b0);
      send(-4, 1'b1, 1'b0);
      drain(2);

      send_zero(99);
      drain(3);
      for (int i = 0; i < 5; i++) send(i + 20, 1'b0, 1'b0);
      send(-77, 1'b0, 1'b1);
      send(55, 1'b1, 1'b0);
      drain(1);

      for (int i = 0; i < 7; i++) send(100 + i, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      k = 0;
      mdl = '0;
      check_idle("mid_reset");
      for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 32767)) - 16384, 1'b0, 1'b0);
      drain(0);

      for (int b = 0; b < 30; b++) begin
         int len;
         if ($urandom_range(0, 5) == 0) begin
            send_zero(int'($urandom_range(0, 100)));
         end else begin
            len = int'($urandom_range(1, 16));
            for (int i = 0; i < len; i++) begin
               bit last;
               last = (i == len - 1) && (len < 16 || $urandom_range(0, 1) == 1);
               send(int'($urandom_range(0, 32767)) - 16384, last, 1'b0);
            end
         end
         drain(int'($urandom_range(0, 4)));
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
